// File: rtl/vga_pkg.sv
// Shared TinyVGA definitions: timing defaults, lock-FSM encoding and PMOD word field positions.
// Used by both the stripe decoder and the pattern generator side.
package vga_pkg;
   localparam int H_TOTAL_DEF     = 800;
   localparam int V_TOTAL_DEF     = 525;
   localparam int H_BP_DEF        = 48;
   localparam int V_BP_DEF        = 33;
   localparam int H_ACTIVE_DEF    = 640;
   localparam int V_ACTIVE_DEF    = 480;
   localparam int MAX_STRIPES_DEF = 16;

   localparam int CNT_W   = 10;
   localparam int COLOR_W = 6;

   // PMOD word {hsync, B0, G0, R0, vsync, B1, G1, R1}
   localparam int BIT_R1    = 0;
   localparam int BIT_G1    = 1;
   localparam int BIT_B1    = 2;
   localparam int BIT_VSYNC = 3;
   localparam int BIT_R0    = 4;
   localparam int BIT_G0    = 5;
   localparam int BIT_B0    = 6;
   localparam int BIT_HSYNC = 7;

   // Both syncs deasserted, black
   localparam logic [7:0] WORD_IDLE = 8'h88;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SYNCING  = 2'd1,
      ST_LOCKED   = 2'd2
   } lock_state_t;

   function automatic logic [COLOR_W-1:0] color_of(input logic [7:0] word);
      return {word[BIT_R1], word[BIT_R0], word[BIT_G1], word[BIT_G0], word[BIT_B1], word[BIT_B0]};
   endfunction
endpackage

// File: rtl/stripe_bank_pp.sv
// Ping-pong stripe store: one bank captures while the other is published; swap flips roles.
module stripe_bank_pp
   import vga_pkg::*;
#(
   parameter int DEPTH = MAX_STRIPES_DEF,
   parameter int WIDTH = COLOR_W,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             swap,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [2][DEPTH];
   logic             sel;   // bank currently capturing; the other one is published

   always_ff @(posedge clk) begin
      if (reset) begin
         sel <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem[b][i] <= '0;
            end
         end
      end else begin
         if (wr_en) begin
            mem[sel][wr_idx] <= wr_data;
         end
         if (swap) begin
            sel <= ~sel;
         end
      end
   end

   assign rd_data = mem[~sel][rd_idx];
endmodule

// File: rtl/vga_stripe_decoder.sv
// Locks onto TinyVGA timing and records the sequence of colour stripes seen down one column,
// publishing each complete frame's stripe list through a ping-pong bank.
module vga_stripe_decoder
   import vga_pkg::*;
#(
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int H_BP        = H_BP_DEF,
   parameter int V_BP        = V_BP_DEF,
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int MAX_STRIPES = MAX_STRIPES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] vga_in,
   input  logic [9:0] sample_x,
   input  logic [3:0] rd_idx,
   output logic [5:0] rd_color,
   output logic [4:0] stripe_count,
   output logic       overflow,
   output logic       locked,
   output logic       frame_done
);
   localparam logic [4:0] MAX_CNT = 5'(MAX_STRIPES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 10'd1;
   endfunction

   logic [7:0]         vin_p0;
   logic               hs_p1, vs_p1;
   logic               hs_edge, vs_edge;
   logic [CNT_W-1:0]   hcount, vcount;
   logic               line_err, frame_err;
   lock_state_t        state, state_next;
   logic               publish, sample_pt, new_stripe, wr_en;
   logic [COLOR_W-1:0] color_p0, prev_color;
   logic [4:0]         wr_count;
   logic               cap_ovf;
   int                 px, py;

   // Stage p0: registered PMOD word; stage p1: sync history for edge detection.
   // History resets to "deasserted" so releasing reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         vin_p0 <= WORD_IDLE;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else begin
         vin_p0 <= vga_in;
         hs_p1  <= vin_p0[BIT_HSYNC];
         vs_p1  <= vin_p0[BIT_VSYNC];
      end
   end

   assign hs_edge  = vin_p0[BIT_HSYNC] & ~hs_p1;
   assign vs_edge  = vin_p0[BIT_VSYNC] & ~vs_p1;
   assign color_p0 = color_of(vin_p0);

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else begin
         hcount <= hs_edge ? '0 : sat_inc(hcount);
         if (vs_edge) begin
            vcount <= '0;
         end else if (hs_edge) begin
            vcount <= sat_inc(vcount);
         end
      end
   end

   assign line_err  = hs_edge && ((int'(hcount) + 1) != H_TOTAL);
   assign frame_err = vs_edge && (int'(vcount) != V_TOTAL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_UNLOCKED;
      end else begin
         state <= state_next;
      end
   end

   // A frame error while syncing restarts the sync window rather than dropping lock entirely.
   always_comb begin
      state_next = state;
      case (state)
         ST_UNLOCKED: if (vs_edge) state_next = ST_SYNCING;
         ST_SYNCING: begin
            if (line_err) begin
               state_next = ST_UNLOCKED;
            end else if (vs_edge && !frame_err) begin
               state_next = ST_LOCKED;
            end
         end
         ST_LOCKED: if (line_err || frame_err) state_next = ST_UNLOCKED;
         default: state_next = ST_UNLOCKED;
      endcase
   end

   assign locked  = (state == ST_LOCKED);
   assign publish = vs_edge && locked && !frame_err && !line_err;

   always_comb begin
      px        = int'(hcount) - H_BP;
      py        = int'(vcount) - V_BP;
      sample_pt = (px == int'(sample_x)) && (px < H_ACTIVE) && (py >= 0) && (py < V_ACTIVE);
   end

   // The frame swap wins over a coincident sample.
   assign new_stripe = locked && sample_pt && !publish && ((py == 0) || (color_p0 != prev_color));
   assign wr_en      = new_stripe && (wr_count != MAX_CNT);

   always_ff @(posedge clk) begin
      if (sample_pt) begin
         prev_color <= color_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_count     <= '0;
         cap_ovf      <= 1'b0;
         stripe_count <= '0;
         overflow     <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= publish;
         if (publish) begin
            stripe_count <= wr_count;
            overflow     <= cap_ovf;
            wr_count     <= '0;
            cap_ovf      <= 1'b0;
         end else if (!locked) begin
            wr_count <= '0;
            cap_ovf  <= 1'b0;
         end else if (new_stripe) begin
            if (wr_count == MAX_CNT) begin
               cap_ovf <= 1'b1;
            end else begin
               wr_count <= wr_count + 5'd1;
            end
         end
      end
   end

   stripe_bank_pp #(
      .DEPTH (MAX_STRIPES),
      .WIDTH (COLOR_W),
      .IDX_W (4)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .swap    (publish),
      .wr_en   (wr_en),
      .wr_idx  (wr_count[3:0]),
      .wr_data (color_p0),
      .rd_idx  (rd_idx),
      .rd_data (rd_color)
   );
endmodule

// File: tb/tb_vga_stripe_decoder.sv
// Directed bench for vga_stripe_decoder using a scaled-down 64x40 timing so whole frames stay short.
module tb_vga_stripe_decoder;
   localparam int HT = 64, VT = 40, HBP = 8, VBP = 4, HA = 40, VA = 30, MS = 16;
   localparam int HSW = 8, VSW = 2, Y0 = VBP + 1, SHORT_GY = 15;
   localparam int PAT_FLAG = 0, PAT_OVF = 1, PAT_BLACK = 2;
   localparam int NFRAMES = 7;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] vga_in;
   logic [9:0] sample_x;
   logic [3:0] rd_idx;
   logic [5:0] rd_color;
   logic [4:0] stripe_count;
   logic       overflow, locked, frame_done;

   vga_stripe_decoder #(
      .H_TOTAL (HT), .V_TOTAL (VT), .H_BP (HBP), .V_BP (VBP),
      .H_ACTIVE (HA), .V_ACTIVE (VA), .MAX_STRIPES (MS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .vga_in       (vga_in),
      .sample_x     (sample_x),
      .rd_idx       (rd_idx),
      .rd_color     (rd_color),
      .stripe_count (stripe_count),
      .overflow     (overflow),
      .locked       (locked),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct { int pat; int sx; int count; logic ovf; } frame_vec_t;
   typedef struct { int idx; logic [5:0] color; } slot_vec_t;

   frame_vec_t frames [NFRAMES];
   slot_vec_t  flag_slots [6];
   slot_vec_t  ovf_slots [16];
   logic [5:0] flag_c [6];
   logic [5:0] ovf_c [20];

   int checks = 0, errors = 0;
   int gx = 0, gy = 0, pat = PAT_FLAG, fd_cnt = 0;
   bit short_line = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] gen_color(input int p, input int line);
      int y;
      y = line - Y0;
      if (y < 0 || y >= VA) return 6'd0;
      if (p == PAT_FLAG) return flag_c[y / 5];
      if (p == PAT_OVF) return (y < 20) ? ovf_c[y] : ovf_c[19];
      return 6'd0;
   endfunction

   function automatic logic [7:0] mk_word(input int x, input int line, input int p);
      logic [5:0] c;
      c = gen_color(p, line);
      return {x >= HSW, c[0], c[2], c[4], line >= VSW, c[1], c[3], c[5]};
   endfunction

   task automatic step();
      int len;
      vga_in = mk_word(gx, gy, pat);
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_cnt++;
      len = (short_line && gy == SHORT_GY) ? HT - 1 : HT;
      if (gx >= len - 1) begin
         gx = 0;
         gy = (gy == VT - 1) ? 0 : gy + 1;
      end else begin
         gx++;
      end
   endtask

   task automatic run_to_line(input int line);
      do step(); while (!(gx == 0 && gy == line));
   endtask

   task automatic check_slots(input int p);
      if (p == PAT_FLAG) begin
         foreach (flag_slots[i]) begin
            rd_idx = 4'(flag_slots[i].idx);
            step();
            chk($sformatf("flag_slot%0d", i), rd_color, flag_slots[i].color);
         end
      end else if (p == PAT_OVF) begin
         foreach (ovf_slots[i]) begin
            rd_idx = 4'(ovf_slots[i].idx);
            step();
            chk($sformatf("ovf_slot%0d", i), rd_color, ovf_slots[i].color);
         end
      end else begin
         rd_idx = 4'd0;
         step();
         chk("black_slot0", rd_color, 6'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      flag_c = '{6'h30, 6'h34, 6'h3C, 6'h0C, 6'h03, 6'h22};
      ovf_c  = '{6'd0, 6'd13, 6'd26, 6'd39, 6'd52, 6'd1, 6'd14, 6'd27, 6'd40, 6'd53,
                 6'd2, 6'd15, 6'd28, 6'd41, 6'd54, 6'd3, 6'd16, 6'd29, 6'd42, 6'd55};
      for (int i = 0; i < 6; i++) flag_slots[i] = '{i, flag_c[i]};
      for (int i = 0; i < 16; i++) ovf_slots[i] = '{i, ovf_c[i]};
      frames[0] = '{PAT_FLAG,  20,     6,  1'b0};
      frames[1] = '{PAT_OVF,   20,     16, 1'b1};
      frames[2] = '{PAT_BLACK, 20,     1,  1'b0};
      frames[3] = '{PAT_BLACK, 20,     1,  1'b0};
      frames[4] = '{PAT_FLAG,  HA,     0,  1'b0};
      frames[5] = '{PAT_OVF,   0,      16, 1'b1};
      frames[6] = '{PAT_FLAG,  HA - 1, 6,  1'b0};

      reset = 1'b1; vga_in = 8'h00; sample_x = 10'd20; rd_idx = 4'd0;
      step();
      step();
      chk("rst_locked", locked, 0);
      chk("rst_stripe_count", stripe_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_rd_color0", rd_color, 0);
      reset = 1'b0;
      rd_idx = 4'd5;
      step();
      chk("rst_rd_color5", rd_color, 0);

      fd_cnt = 0;
      run_to_line(3);
      chk("locked_after_vs1", locked, 0);
      run_to_line(3);
      chk("locked_after_vs2", locked, 1);
      chk("no_done_before_vs3", fd_cnt, 0);

      for (int f = 0; f < NFRAMES; f++) begin
         pat = frames[f].pat;
         sample_x = 10'(frames[f].sx);
         fd_cnt = 0;
         run_to_line(3);
         chk($sformatf("f%0d_frame_done", f), fd_cnt, 1);
         chk($sformatf("f%0d_stripe_count", f), stripe_count, frames[f].count);
         chk($sformatf("f%0d_overflow", f), overflow, frames[f].ovf);
         chk($sformatf("f%0d_locked", f), locked, 1);
         if (frames[f].count > 0) check_slots(frames[f].pat);
      end

      // Short line while locked: published flag result must survive.
      pat = PAT_BLACK; sample_x = 10'd20; fd_cnt = 0;
      short_line = 1'b1;
      run_to_line(SHORT_GY + 1);
      short_line = 1'b0;
      for (int i = 0; i <= HSW; i++) step();
      chk("short_locked_before", locked, 1);
      step();
      chk("short_locked_after", locked, 0);
      run_to_line(3);
      chk("short_no_done", fd_cnt, 0);
      chk("short_locked_resync", locked, 0);
      chk("short_count_kept", stripe_count, 6);
      chk("short_ovf_kept", overflow, 0);
      rd_idx = 4'd5;
      step();
      chk("short_slot5_kept", rd_color, 6'h22);

      pat = PAT_OVF;
      run_to_line(3);
      chk("relock_locked", locked, 1);
      chk("relock_no_done", fd_cnt, 0);
      chk("relock_count_kept", stripe_count, 6);
      run_to_line(3);
      chk("relock_done", fd_cnt, 1);
      chk("relock_count", stripe_count, 16);
      chk("relock_ovf", overflow, 1);

      // Reset in the middle of a locked frame.
      run_to_line(20);
      rd_idx = 4'd1;
      reset = 1'b1;
      step();
      chk("midrst_locked", locked, 0);
      chk("midrst_count", stripe_count, 0);
      chk("midrst_ovf", overflow, 0);
      chk("midrst_done", frame_done, 0);
      chk("midrst_rd_color", rd_color, 0);
      reset = 1'b0;
      pat = PAT_FLAG; fd_cnt = 0;
      run_to_line(3);
      chk("postrst_vs1_locked", locked, 0);
      run_to_line(3);
      chk("postrst_vs2_locked", locked, 1);
      chk("postrst_vs2_no_done", fd_cnt, 0);
      run_to_line(3);
      chk("postrst_vs3_done", fd_cnt, 1);
      chk("postrst_count", stripe_count, 6);
      check_slots(PAT_FLAG);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
